stg1if: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of stg2id and drives its iw_pc/iw_instr.

---
 rtl/stg1if_pkg.sv | 16 +
 rtl/stg1if_fifo.sv | 55 +++++
 rtl/stg1if.sv | 134 +++++++++++++
 tb/tb_stg1if.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stg1if_pkg.sv
// Shared sizes and payload types for the instruction-fetch stage.
package stg1if_pkg;

  localparam int unsigned SIZE_ADDR     = 32;
  localparam int unsigned SIZE_DATA     = 32;
  localparam int unsigned SIZE_IF_DEPTH = 4;

  // One fetched instruction together with the pc it was fetched from.
  typedef struct packed {
    logic [SIZE_ADDR-1:0] pc;
    logic [SIZE_DATA-1:0] instr;
  } if_entry_t;

  localparam int unsigned IF_ENTRY_W = $bits(if_entry_t);

endpackage

// File: rtl/stg1if_fifo.sv
// Synchronous FIFO with flush; head word is readable without popping.
module stg1if_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty_c,
  output logic                     full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees the slot a simultaneous push at full level needs.
  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);
  assign rdata_c = mem[rd_ptr];

  // Storage, pointers and occupancy; flush takes priority over push/pop.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/stg1if.sv
// Instruction-fetch stage: issues in-order fetches, tracks in-flight pcs,
// buffers returned words and presents one {pc, instr} per cycle.
module stg1if
  import stg1if_pkg::*;
#(
  parameter logic [SIZE_ADDR-1:0] RESET_PC = '0,
  parameter int unsigned          DEPTH    = SIZE_IF_DEPTH
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  output logic                 ow_imem_req,
  output logic [SIZE_ADDR-1:0] ow_imem_addr,
  input  logic                 iw_imem_ready,
  input  logic                 iw_imem_valid,
  input  logic [SIZE_DATA-1:0] iw_imem_data,
  input  logic                 iw_stall,
  input  logic                 iw_redirect,
  input  logic [SIZE_ADDR-1:0] iw_redirect_pc,
  output logic [SIZE_ADDR-1:0] ow_pc,
  output logic [SIZE_DATA-1:0] ow_instr,
  output logic                 ow_valid
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [SIZE_ADDR-1:0] fetch_pc;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        drop_nxt;
  logic [CW-1:0]        pcq_count;
  logic [CW-1:0]        buf_count;
  logic [CW:0]          in_use_c;
  logic                 pcq_empty;
  logic                 pcq_full;
  logic                 buf_empty;
  logic                 buf_full;
  logic [SIZE_ADDR-1:0] pcq_head;
  if_entry_t            buf_head;
  if_entry_t            buf_wdata;
  logic                 accept;
  logic                 drop_hit;
  logic                 resp_live;
  logic                 buf_pop;

  // Credits cover both queues, so neither FIFO can overflow.
  assign in_use_c    = {1'b0, pcq_count} + {1'b0, buf_count};
  assign ow_imem_req = !iw_rst && !iw_redirect && (in_use_c < (CW+1)'(DEPTH));
  assign ow_imem_addr = fetch_pc;
  assign accept      = ow_imem_req && iw_imem_ready;

  // Responses owed to flushed requests are eaten by the drop counter first.
  assign drop_hit  = iw_imem_valid && (drop_cnt != '0);
  assign resp_live = iw_imem_valid && (drop_cnt == '0);
  assign buf_wdata = '{pc: pcq_head, instr: iw_imem_data};
  assign buf_pop   = !iw_redirect && !iw_stall && !buf_empty;

  stg1if_fifo #(.WIDTH(SIZE_ADDR), .DEPTH(DEPTH)) u_pcq (
    .iw_clk  (iw_clk),
    .iw_rst  (iw_rst),
    .push    (accept),
    .wdata   (fetch_pc),
    .pop     (resp_live),
    .flush   (iw_redirect),
    .rdata_c (pcq_head),
    .count   (pcq_count),
    .empty_c (pcq_empty),
    .full_c  (pcq_full)
  );

  stg1if_fifo #(.WIDTH(IF_ENTRY_W), .DEPTH(DEPTH)) u_buf (
    .iw_clk  (iw_clk),
    .iw_rst  (iw_rst),
    .push    (resp_live),
    .wdata   (buf_wdata),
    .pop     (buf_pop),
    .flush   (iw_redirect),
    .rdata_c (buf_head),
    .count   (buf_count),
    .empty_c (buf_empty),
    .full_c  (buf_full)
  );

  // Fetch pc: reset, redirect target, or advance on accepted request.
  always_ff @(posedge iw_clk) begin
    if (iw_rst)           fetch_pc <= RESET_PC;
    else if (iw_redirect) fetch_pc <= iw_redirect_pc;
    else if (accept)      fetch_pc <= fetch_pc + SIZE_ADDR'(1);
  end

  // Every response removes one outstanding request (stale or live); a redirect
  // turns all live in-flight requests into stale ones.
  always_comb begin
    drop_nxt = drop_cnt;
    if (iw_redirect)   drop_nxt = drop_cnt - CW'(drop_hit) + pcq_count - CW'(resp_live);
    else if (drop_hit) drop_nxt = drop_cnt - CW'(1);
  end

  // Drop counter register.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) drop_cnt <= '0;
    else        drop_cnt <= drop_nxt;
  end

  // Output register: redirect clears, stall holds, otherwise load buffer head.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      ow_valid <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= '0;
    end else if (iw_redirect) begin
      ow_valid <= 1'b0;
      ow_instr <= '0;
    end else if (!iw_stall) begin
      if (!buf_empty) begin
        ow_valid <= 1'b1;
        ow_pc    <= buf_head.pc;
        ow_instr <= buf_head.instr;
      end else begin
        ow_valid <= 1'b0;
        ow_instr <= '0;
      end
    end
  end

  // Protocol sanity: bounded drop count, no response without a tracked pc.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      assert (drop_cnt <= CW'(DEPTH));
      assert (!(resp_live && pcq_empty));
      assert (!(accept && pcq_full));
      assert (!(resp_live && buf_full && !buf_pop));
    end
  end

endmodule

// File: tb/tb_stg1if.sv
// Directed and randomized bench for stg1if against an epoch-based fetch model.
module tb_stg1if;
  import stg1if_pkg::*;

  localparam int unsigned AW    = SIZE_ADDR;
  localparam int unsigned DW    = SIZE_DATA;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RST_PC = '0;

  logic          iw_clk;
  logic          iw_rst;
  logic          ow_imem_req;
  logic [AW-1:0] ow_imem_addr;
  logic          iw_imem_ready;
  logic          iw_imem_valid;
  logic [DW-1:0] iw_imem_data;
  logic          iw_stall;
  logic          iw_redirect;
  logic [AW-1:0] iw_redirect_pc;
  logic [AW-1:0] ow_pc;
  logic [DW-1:0] ow_instr;
  logic          ow_valid;

  stg1if #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .iw_clk         (iw_clk),
    .iw_rst         (iw_rst),
    .ow_imem_req    (ow_imem_req),
    .ow_imem_addr   (ow_imem_addr),
    .iw_imem_ready  (iw_imem_ready),
    .iw_imem_valid  (iw_imem_valid),
    .iw_imem_data   (iw_imem_data),
    .iw_stall       (iw_stall),
    .iw_redirect    (iw_redirect),
    .iw_redirect_pc (iw_redirect_pc),
    .ow_pc          (ow_pc),
    .ow_instr       (ow_instr),
    .ow_valid       (ow_valid)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  // Outstanding memory request: due edge, fetch epoch it belongs to, address.
  typedef struct { int due; int ep; logic [AW-1:0] pc; } req_t;
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] ins; } out_t;

  req_t          pend[$];
  out_t          bufq[$];
  int            edge_n, epoch, lat;
  logic [AW-1:0] m_pc, m_opc;
  logic [DW-1:0] m_ins;
  logic          m_valid;
  int            n_cmp, n_err;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs and memory response, check request side, clock,
  // advance the model, check the presented instruction.
  task automatic tick(input logic rst, input logic stall, input logic ready,
                      input logic redir, input logic [AW-1:0] rpc);
    logic resp, exp_req;
    req_t h;
    iw_rst = rst; iw_stall = stall; iw_imem_ready = ready;
    iw_redirect = redir; iw_redirect_pc = rpc;
    resp = !rst && (pend.size() > 0) && (pend[0].due == edge_n + 1);
    iw_imem_valid = resp;
    iw_imem_data  = resp ? mem_word(pend[0].pc) : DW'($urandom);
    exp_req = !rst && !redir && ((live_cnt() + bufq.size()) < DEPTH);
    #1;
    check("imem_req", 64'(ow_imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(ow_imem_addr), 64'(m_pc));
    @(posedge iw_clk);
    edge_n++;
    if (rst) begin
      pend.delete(); bufq.delete(); epoch++;
      m_pc = RST_PC; m_valid = 1'b0; m_opc = '0; m_ins = '0;
    end else begin
      if (resp) h = pend.pop_front();
      if (redir) begin
        epoch++; bufq.delete();
        m_pc = rpc; m_valid = 1'b0; m_ins = '0;
      end else begin
        if (!stall) begin
          if (bufq.size() > 0) begin
            out_t o = bufq.pop_front();
            m_valid = 1'b1; m_opc = o.pc; m_ins = o.ins;
          end else begin
            m_valid = 1'b0; m_ins = '0;
          end
        end
        if (resp && h.ep == epoch) bufq.push_back('{h.pc, mem_word(h.pc)});
        if (exp_req && ready) begin
          pend.push_back('{edge_n + lat, epoch, m_pc});
          m_pc = m_pc + AW'(1);
        end
      end
    end
    #1;
    check("ow_valid", 64'(ow_valid), 64'(m_valid));
    check("ow_pc", 64'(ow_pc), 64'(m_opc));
    check("ow_instr", 64'(ow_instr), 64'(m_ins));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    bit found;
    n_cmp = 0; n_err = 0; edge_n = 0; epoch = 0; lat = 1;
    m_pc = '0; m_opc = '0; m_ins = '0; m_valid = 1'b0;
    iw_rst = 1'b1; iw_stall = 1'b0; iw_imem_ready = 1'b0; iw_imem_valid = 1'b0;
    iw_imem_data = '0; iw_redirect = 1'b0; iw_redirect_pc = '0;
    @(negedge iw_clk);

    // Reset, then streaming at latency 1: first valid three edges after release.
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("rst_valid", 64'(ow_valid), 64'd0);
    check("rst_addr", 64'(ow_imem_addr), 64'(RST_PC));
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      if (k == 2) check("lat_not_yet", 64'(ow_valid), 64'd0);
      if (k == 3) begin
        check("lat_first_valid", 64'(ow_valid), 64'd1);
        check("lat_first_pc", 64'(ow_pc), 64'd0);
        check("lat_first_instr", 64'(ow_instr), 64'(mem_word(32'd0)));
      end
    end

    // Stall three cycles, then memory not ready for five.
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    run(6);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    run(6);

    // Redirect near the top of the address space: pc wraps to zero.
    tick(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    run(8);

    // Redirect together with a response and a stall.
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("redir_stall_valid", 64'(ow_valid), 64'd0);
    run(6);

    // Back-to-back redirects: the second target wins.
    tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    run(8);

    // One-cycle reset mid-stream.
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("midrst_valid", 64'(ow_valid), 64'd0);
    check("midrst_addr", 64'(ow_imem_addr), 64'(RST_PC));
    run(6);

    // Latency 3, redirect to 0x40 with requests in flight.
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    lat = 3;
    run(8);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      if (ow_valid === 1'b1) found = 1'b1;
    end
    check("redir40_seen", 64'(found), 64'd1);
    check("redir40_pc", 64'(ow_pc), 64'h40);
    check("redir40_instr", 64'(ow_instr), 64'(mem_word(32'h40)));
    run(6);

    // Randomized segments, each starting from reset with its own latency.
    for (int seg = 0; seg < 4; seg++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
      lat = int'($urandom_range(1, 4));
      for (int k = 0; k < 150; k++) begin
        logic st, rd, rx;
        st = ($urandom % 4) == 0;
        rd = ($urandom % 5) != 0;
        rx = (($urandom % 16) == 0) && (pend.size() <= DEPTH);
        tick(1'b0, st, rd, rx, AW'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
